// File: rtl/seg_share_if.sv
// Bundle between the requesters, the shared 7-segment decoder and seg_share_ctrl.
// The controller takes the slave side; the requesters and the decoder take the master side.
interface seg_share_if #(
  parameter int NUM_DIGITS = 4
);
  logic [NUM_DIGITS-1:0]   req;
  logic [5*NUM_DIGITS-1:0] val;
  logic [NUM_DIGITS-1:0]   ack;
  logic [4:0]              dec_out;
  logic [6:0]              seven_in;
  logic [7*NUM_DIGITS-1:0] hex;
  logic                    busy;

  modport master (output req, val, seven_in, input ack, dec_out, hex, busy);
  modport slave  (input req, val, seven_in, output ack, dec_out, hex, busy);
endinterface

// File: rtl/seg_share_ctrl.sv
// Round-robin sequencer sharing one 7-segment decoder among NUM_DIGITS requesters.
// Each service takes three cycles: grant, decoder settle, capture + ack.

module seg_digit #(
  parameter logic [6:0] BLANK = 7'b1111111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic [6:0] d,
  output logic [6:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  q <= BLANK;
    else if (wr) q <= d;
endmodule

module seg_share_ctrl #(
  parameter int         NUM_DIGITS = 4,
  parameter logic [6:0] BLANK      = 7'b1111111
) (
  input  logic     clk,
  input  logic     rst_n,
  seg_share_if.slave bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t                        state, state_nxt;
  logic [IDX_W-1:0]              g, last, win;
  logic                          blank_q;
  logic [4:0]                    dec_q;
  logic [NUM_DIGITS-1:0]         ack_q, elig, wr;
  logic                          any_elig;
  logic [6:0]                    cap_d;
  logic [NUM_DIGITS-1:0][4:0]    val_a;
  logic [NUM_DIGITS-1:0][6:0]    hex_a;

  assign val_a = bus.val;
  // A requester in its ack cycle is masked so it cannot be re-granted back-to-back.
  assign elig  = bus.req & ~ack_q;

  always_comb begin
    win      = '0;
    any_elig = 1'b0;
    for (int k = 1; k <= NUM_DIGITS; k++) begin
      if (!any_elig && elig[(int'(last) + k) % NUM_DIGITS]) begin
        win      = IDX_W'((int'(last) + k) % NUM_DIGITS);
        any_elig = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_elig) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      g       <= '0;
      blank_q <= 1'b0;
      last    <= IDX_W'(NUM_DIGITS - 1);
      dec_q   <= '0;
      ack_q   <= '0;
    end else begin
      ack_q <= '0;
      case (state)
        IDLE: if (any_elig) begin
          g       <= win;
          blank_q <= val_a[win][4];
          // Bit 4 never reaches the decoder; out-of-range codes are blanked at capture.
          dec_q   <= {1'b0, val_a[win][3:0]};
        end
        CAPTURE: begin
          ack_q[g] <= 1'b1;
          last     <= g;
        end
        default: ;
      endcase
    end

  assign cap_d = blank_q ? BLANK : bus.seven_in;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign wr[i] = (state == CAPTURE) && (g == IDX_W'(i));
    seg_digit #(.BLANK(BLANK)) u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (wr[i]),
      .d     (cap_d),
      .q     (hex_a[i])
    );
  end

  assign bus.hex     = hex_a;
  assign bus.ack     = ack_q;
  assign bus.dec_out = dec_q;
  assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_seg_share_ctrl.sv
// Scoreboard bench for seg_share_ctrl: a transaction-level model predicts each service
// (winner, capture cycle, hex image) and a negedge monitor checks every ack against it.
module tb_seg_share_ctrl;
  localparam int         N     = 4;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_share_if #(.NUM_DIGITS(N)) bus ();

  seg_share_ctrl #(.NUM_DIGITS(N), .BLANK(BLANK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'h0: seg = 7'b1000000;  4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;  4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;  4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;  4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;  4'h9: seg = 7'b0011000;
      4'hA: seg = 7'b0001000;  4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;  4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;  default: seg = 7'b0001110;
    endcase
  endfunction

  // Shared decoder modelled as a purely combinational table on dec_out.
  assign bus.seven_in = seg(bus.dec_out[3:0]);

  logic [N-1:0]      rq;
  logic [N-1:0][4:0] vl;
  assign bus.req = rq;
  assign bus.val = vl;

  typedef struct {
    int               g;
    logic [6:0]       hx;
    logic [7*N-1:0]   full;
    int               at;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: services are atomic 3-cycle slots.
  logic [N-1:0][6:0] m_hex;
  int m_last, m_free, m_done_at, m_done_g;

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_hex[i] = BLANK;
    m_last    = N - 1;
    m_free    = 0;
    m_done_at = -10;
    m_done_g  = 0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Predict the service that begins at the coming edge, from the inputs now applied.
  task automatic model_step();
    int e, w;
    logic [N-1:0] ackv, el;
    exp_t x;
    e    = cyc + 1;
    ackv = '0;
    if (m_done_at == cyc) ackv[m_done_g] = 1'b1;
    if (!rst_n || e < m_free) return;
    el = rq & ~ackv;
    w  = -1;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (w < 0 && el[i]) w = i;
    end
    if (w < 0) return;
    m_hex[w]  = vl[w][4] ? BLANK : seg(vl[w][3:0]);
    x.g       = w;
    x.hx      = m_hex[w];
    x.full    = m_hex;
    x.at      = e + 2;
    q.push_back(x);
    m_last    = w;
    m_free    = e + 3;
    m_done_at = e + 2;
    m_done_g  = w;
  endtask

  task automatic go();
    model_step();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t x;
    logic [N-1:0] oh;
    if (rst_n) begin
      if (q.size() > 0 && q[0].at < cyc) begin
        checks++; errors++;
        $display("FAIL ack_missing: digit %0d no ack, required at cycle %0d", q[0].g, q[0].at);
        x = q.pop_front();
      end
      if (bus.ack != '0) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ack_spurious: got ack %b required 0 (cycle %0d)", bus.ack, cyc);
        end else begin
          x  = q.pop_front();
          oh = '0;
          oh[x.g] = 1'b1;
          chk("ack_vec",   bus.ack, oh);
          chk("ack_cycle", cyc, x.at);
          chk("hex_digit", bus.hex[7*x.g +: 7], x.hx);
          chk("hex_all",   bus.hex, x.full);
        end
      end
    end
  end

  initial begin
    rq = '0;
    vl = '0;
    m_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_hex",  bus.hex, {N{BLANK}});
    chk("rst_ack",  bus.ack, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_dec",  bus.dec_out, 0);

    // Abort a service with reset while it is in its capture cycle.
    rq[2] = 1'b1; vl[2] = 5'd5;
    go(); go();
    chk("busy_capture", bus.busy, 1);
    rst_n = 1'b0; q.delete(); m_reset(); rq = '0;
    #1;
    chk("abort_hex",  bus.hex, {N{BLANK}});
    chk("abort_ack",  bus.ack, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_dec",  bus.dec_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    go(); go(); go();
    chk("abort_hex2", bus.hex[20:14], BLANK);

    // First request after reset: digit 1, code 3.
    rq[1] = 1'b1; vl[1] = 5'd3;
    go();
    chk("d1_dec", bus.dec_out, 5'd3);
    chk("d1_busy0", bus.busy, 1);
    go();
    chk("d1_busy1", bus.busy, 1);
    chk("d1_noack", bus.ack, 0);
    go();
    chk("d1_ack", bus.ack, 4'b0010);
    chk("d1_hex", bus.hex[13:7], 7'b0110000);
    chk("d1_busy2", bus.busy, 0);
    rq[1] = 1'b0;
    go();
    chk("d1_ackfall", bus.ack, 0);

    // Single digit 0, code 7.
    rq[0] = 1'b1; vl[0] = 5'b00111;
    go();
    chk("d0_dec", bus.dec_out, 5'd7);
    chk("d0_busy", bus.busy, 1);
    go(); go();
    chk("d0_ack", bus.ack, 4'b0001);
    chk("d0_hex", bus.hex[6:0], 7'b1111000);
    rq[0] = 1'b0;
    go();
    chk("d0_ackfall", bus.ack, 0);

    // Contention: every digit requesting continuously.
    vl[0] = 5'd0; vl[1] = 5'd1; vl[2] = 5'd2; vl[3] = 5'd9;
    rq = 4'b1111;
    repeat (15) go();
    rq = '0;
    repeat (4) go();
    chk("cont_hex", bus.hex, {7'b0011000, 7'b0100100, 7'b1111001, 7'b1000000});

    // Out-of-range code blanks the digit; decoder sees only the low nibble.
    rq[2] = 1'b1; vl[2] = 5'b10110;
    go();
    chk("oor_dec", bus.dec_out, 5'b00110);
    go(); go();
    chk("oor_ack", bus.ack, 4'b0100);
    chk("oor_hex", bus.hex[20:14], BLANK);
    rq[2] = 1'b0;
    go();

    // Code changes after the grant are ignored.
    rq[1] = 1'b1; vl[1] = 5'd4;
    go();
    vl[1] = 5'd8;
    go(); go();
    chk("late_val_hex", bus.hex[13:7], 7'b0011001);
    rq[1] = 1'b0;
    go();

    // Request dropped after the grant still completes.
    rq[3] = 1'b1; vl[3] = 5'd5;
    go();
    rq[3] = 1'b0;
    go(); go();
    chk("drop_ack", bus.ack, 4'b1000);
    chk("drop_hex", bus.hex[27:21], 7'b0010010);
    go();

    // Wrap from last=3, with digit 0 held high through its ack.
    vl[0] = 5'd6; vl[3] = 5'd8;
    rq = 4'b1001;
    go(); go(); go();
    chk("wrap_first", bus.ack, 4'b0001);
    go(); go(); go();
    chk("wrap_second", bus.ack, 4'b1000);
    rq = '0;
    go();

    // Randomized requesters that obey the hold-until-ack rule.
    repeat (900) begin
      for (int i = 0; i < N; i++) begin
        if (bus.ack[i]) begin
          if ($urandom_range(1, 0) == 0) rq[i] = 1'b0;
          else vl[i] = 5'($urandom);
        end else if (!rq[i] && $urandom_range(3, 0) == 0) begin
          rq[i] = 1'b1;
          vl[i] = 5'($urandom);
        end
      end
      go();
    end
    rq = '0;
    repeat (8) go();
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
